// File: rtl/sudoku_board_checker_if.sv
// Handshake and result bundle for the sudoku board checker.
// The master drives the board and start; the slave returns status and results.
interface sudoku_board_checker_if;
   logic [323:0] board_in;
   logic         start_in;
   logic         busy_out;
   logic         done_out;
   logic         solved_out;
   logic         error_out;
   logic [4:0]   fail_unit_out;
   logic [6:0]   empty_count_out;

   modport master (
      output board_in, start_in,
      input  busy_out, done_out, solved_out, error_out,
      input  fail_unit_out, empty_count_out
   );

   modport slave (
      input  board_in, start_in,
      output busy_out, done_out, solved_out, error_out,
      output fail_unit_out, empty_count_out
   );
endinterface

// File: rtl/sudoku_board_checker.sv
// Sequential 9x9 sudoku board checker: one unit (row, column, square) per cycle.
// Results are published together in DONE and held until the next DONE.
module sudoku_board_checker #(
   parameter int GRID_SIZE = 9
) (
   input  logic clk_in,
   input  logic reset_in,
   sudoku_board_checker_if.slave bus
);
   localparam int CELLS = GRID_SIZE * GRID_SIZE;
   localparam logic [4:0] LAST_UNIT = 5'(3 * GRID_SIZE);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state;
   state_t            next;
   logic [CELLS*4-1:0] snap;
   logic [4:0]        cnt;
   logic              fail_any;
   logic [4:0]        first_fail;
   logic [6:0]        zero_acc;

   logic              res_solved;
   logic              res_error;
   logic [4:0]        res_fail_unit;
   logic [6:0]        res_empty;

   logic [3:0]        val;
   logic [15:0]       seen;
   logic              unit_fail;
   logic [3:0]        unit_zeros;
   int                r;
   int                c;
   int                sq;

   // State register
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state <= IDLE;
      else          state <= next;
   end

   // Next-state logic; cnt reaching LAST_UNIT is the spare cycle after unit 26
   always_comb begin
      next = state;
      unique case (state)
         IDLE:    if (bus.start_in) next = SCAN;
         SCAN:    if (cnt == LAST_UNIT) next = DONE;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Evaluate the unit selected by cnt over the snapshot
   always_comb begin
      unit_fail  = 1'b0;
      seen       = '0;
      unit_zeros = '0;
      val        = '0;
      r          = 0;
      c          = 0;
      sq         = 0;
      for (int k = 0; k < 9; k++) begin
         if (cnt < 5'd9) begin
            r = int'(cnt);
            c = k;
         end else if (cnt < 5'd18) begin
            r = k;
            c = int'(cnt) - 9;
         end else begin
            sq = int'(cnt) - 18;
            if (sq > 8) sq = 8;
            r = (sq / 3) * 3 + k / 3;
            c = (sq % 3) * 3 + k % 3;
         end
         val = snap[(r * 9 + c) * 4 +: 4];
         if (val > 4'd9) begin
            unit_fail = 1'b1;
         end else if (val == 4'd0) begin
            unit_zeros = unit_zeros + 4'd1;
         end else begin
            if (seen[val]) unit_fail = 1'b1;
            seen[val] = 1'b1;
         end
      end
   end

   // Snapshot, unit counter, accumulators and published results
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         snap          <= '0;
         cnt           <= '0;
         fail_any      <= 1'b0;
         first_fail    <= '0;
         zero_acc      <= '0;
         res_solved    <= 1'b0;
         res_error     <= 1'b0;
         res_fail_unit <= 5'd31;
         res_empty     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start_in) begin
                  snap       <= bus.board_in;
                  cnt        <= '0;
                  fail_any   <= 1'b0;
                  first_fail <= '0;
                  zero_acc   <= '0;
               end
            end
            SCAN: begin
               if (cnt == LAST_UNIT) begin
                  res_error     <= fail_any;
                  res_solved    <= !fail_any && (zero_acc == 7'd0);
                  res_fail_unit <= fail_any ? first_fail : 5'd31;
                  res_empty     <= zero_acc;
               end else begin
                  cnt <= cnt + 5'd1;
                  if (unit_fail) begin
                     fail_any <= 1'b1;
                     if (!fail_any) first_fail <= cnt;
                  end
                  if (cnt < 5'd9) zero_acc <= zero_acc + 7'(unit_zeros);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_out        = (state == SCAN);
   assign bus.done_out        = (state == DONE);
   assign bus.solved_out      = res_solved;
   assign bus.error_out       = res_error;
   assign bus.fail_unit_out   = res_fail_unit;
   assign bus.empty_count_out = res_empty;
endmodule

// File: tb/tb_sudoku_board_checker.sv
// Directed and randomized bench for sudoku_board_checker.
// Expected results come from a unit-by-unit digit-count model of the board.
module tb_sudoku_board_checker;
   logic clk_in = 1'b0;
   logic reset_in;
   int   checks = 0;
   int   errors = 0;
   int   brd[81];
   int   exp_solved, exp_err, exp_fu, exp_empty;
   int   p_solved = 0, p_err = 0, p_fu = 31, p_empty = 0;

   sudoku_board_checker_if ifc ();

   sudoku_board_checker #(.GRID_SIZE(9)) dut (
      .clk_in  (clk_in),
      .reset_in(reset_in),
      .bus     (ifc.slave)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic base_board();
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            brd[r*9+c] = ((r*3 + r/3 + c) % 9) + 1;
   endtask

   task automatic pack();
      for (int i = 0; i < 81; i++)
         ifc.board_in[i*4 +: 4] = 4'(brd[i]);
   endtask

   task automatic model();
      int cntv[16];
      int r, c, s;
      bit f;
      exp_empty = 0;
      exp_fu    = 31;
      for (int i = 0; i < 81; i++)
         if (brd[i] == 0) exp_empty++;
      for (int u = 0; u < 27; u++) begin
         for (int v = 0; v < 16; v++) cntv[v] = 0;
         for (int k = 0; k < 9; k++) begin
            if (u < 9) begin
               r = u; c = k;
            end else if (u < 18) begin
               r = k; c = u - 9;
            end else begin
               s = u - 18;
               r = 3*(s/3) + k/3;
               c = 3*(s%3) + k%3;
            end
            cntv[brd[r*9+c]]++;
         end
         f = 0;
         for (int v = 10; v < 16; v++) if (cntv[v] > 0) f = 1;
         for (int v = 1; v < 10; v++) if (cntv[v] > 1) f = 1;
         if (f && exp_fu == 31) exp_fu = u;
      end
      exp_err    = (exp_fu != 31) ? 1 : 0;
      exp_solved = (exp_err == 0 && exp_empty == 0) ? 1 : 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".busy"}, 32'(ifc.busy_out), 0);
      chk({tag, ".done"}, 32'(ifc.done_out), 0);
      chk({tag, ".solved"}, 32'(ifc.solved_out), 0);
      chk({tag, ".error"}, 32'(ifc.error_out), 0);
      chk({tag, ".fail_unit"}, 32'(ifc.fail_unit_out), 31);
      chk({tag, ".empty"}, 32'(ifc.empty_count_out), 0);
   endtask

   task automatic chk_results(input string tag);
      chk({tag, ".solved"}, 32'(ifc.solved_out), 32'(exp_solved));
      chk({tag, ".error"}, 32'(ifc.error_out), 32'(exp_err));
      chk({tag, ".fail_unit"}, 32'(ifc.fail_unit_out), 32'(exp_fu));
      chk({tag, ".empty"}, 32'(ifc.empty_count_out), 32'(exp_empty));
      chk({tag, ".excl"}, 32'(ifc.solved_out & ifc.error_out), 0);
   endtask

   // mode 0: plain pulse; 1: disturb board at E5 and pulse start at E10;
   // 2: start held high, expect a second back-to-back check
   task automatic run_check(input string tag, input int mode);
      int n, g, dones;
      model();
      pack();
      ifc.start_in = 1'b1;
      tick();
      if (mode != 2) ifc.start_in = 1'b0;
      n = 0;
      while (ifc.done_out !== 1'b1 && n < 40) begin
         chk({tag, ".busy"}, 32'(ifc.busy_out), 1);
         chk({tag, ".hold_fu"}, 32'(ifc.fail_unit_out), 32'(p_fu));
         chk({tag, ".hold_err"}, 32'(ifc.error_out), 32'(p_err));
         if (mode == 1 && n == 4) ifc.board_in = ~ifc.board_in;
         if (mode == 1 && n == 9) ifc.start_in = 1'b1;
         if (mode == 1 && n == 10) ifc.start_in = 1'b0;
         tick();
         n++;
      end
      chk({tag, ".latency"}, 32'(n), 28);
      chk({tag, ".done"}, 32'(ifc.done_out), 1);
      chk({tag, ".busy_done"}, 32'(ifc.busy_out), 0);
      chk_results(tag);
      p_solved = exp_solved;
      p_err    = exp_err;
      p_fu     = exp_fu;
      p_empty  = exp_empty;
      tick();
      chk({tag, ".done_pulse"}, 32'(ifc.done_out), 0);
      if (mode == 1) begin
         dones = 0;
         for (int i = 0; i < 40; i++) begin
            if (ifc.done_out === 1'b1 || ifc.busy_out === 1'b1) dones++;
            tick();
         end
         chk({tag, ".no_requeue"}, 32'(dones), 0);
      end
      if (mode == 2) begin
         g = 1;
         while (ifc.done_out !== 1'b1 && g < 40) begin
            tick();
            g++;
         end
         chk({tag, ".period_ok"}, 32'(g == 29 || g == 30), 1);
         chk_results({tag, ".2nd"});
         ifc.start_in = 1'b0;
         tick();
         tick();
         chk({tag, ".idle"}, 32'(ifc.busy_out), 0);
      end
   endtask

   initial begin
      int perm[9];
      int j, t, dones;
      reset_in       = 1'b1;
      ifc.start_in   = 1'b0;
      ifc.board_in   = '0;
      #2;
      chk_reset_vals("reset_async");
      tick();
      tick();
      chk_reset_vals("reset_clk");
      reset_in = 1'b0;
      tick();
      chk_reset_vals("post_reset");

      base_board();
      run_check("solved", 0);

      base_board();
      brd[0] = 0;
      brd[4*9+4] = 0;
      run_check("two_blank", 0);

      base_board();
      brd[5*9+2] = brd[5*9+3];
      run_check("dup_row5", 0);

      for (int i = 0; i < 81; i++) brd[i] = 0;
      brd[8*9+7] = 12;
      run_check("bad_value", 0);

      base_board();
      brd[13] = 0;
      run_check("disturb", 1);

      base_board();
      brd[3*9+3] = brd[3*9+4];
      pack();
      ifc.start_in = 1'b1;
      tick();
      ifc.start_in = 1'b0;
      repeat (14) tick();
      reset_in = 1'b1;
      #1;
      chk_reset_vals("abort");
      tick();
      tick();
      chk_reset_vals("abort_held");
      reset_in = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifc.done_out === 1'b1) dones++;
         tick();
      end
      chk("abort_no_done", 32'(dones), 0);
      p_solved = 0; p_err = 0; p_fu = 31; p_empty = 0;
      run_check("after_abort", 0);

      base_board();
      run_check("continuous", 2);

      for (t = 0; t < 8; t++) begin
         for (int i = 0; i < 9; i++) perm[i] = i + 1;
         for (int i = 8; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            {perm[i], perm[j]} = {perm[j], perm[i]};
         end
         base_board();
         for (int i = 0; i < 81; i++) brd[i] = perm[brd[i] - 1];
         repeat ($urandom_range(0, 3)) brd[$urandom_range(0, 80)] = 0;
         if ($urandom_range(0, 2) != 0)
            brd[$urandom_range(0, 80)] = int'($urandom_range(0, 15));
         run_check($sformatf("rand%0d", t), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
